// File: rtl/dsp_pd_pkg.sv
// Shared widths and types for the pattern-detecting multiplier.
// DSP_PD_MASK_EN (optional) enables the per-sample compare mask in the top level.
package dsp_pd_pkg;

  localparam int unsigned WIDTH_IN1_DEF = 26;
  localparam int unsigned WIDTH_IN2_DEF = 14;
  localparam int unsigned WIDTH_OUT_DEF = 40;

  localparam int unsigned PROD_FULL_W = WIDTH_IN1_DEF + WIDTH_IN2_DEF + 2;

  typedef logic [WIDTH_OUT_DEF:0] result_t;

endpackage

// File: rtl/dsp_pd_cmp.sv
// Combinational masked equality: match when every unmasked bit of value equals pattern.
module dsp_pd_cmp #(
  parameter int unsigned WIDTH = 41
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  output logic             match
);

  assign match = ((value ^ pattern) & ~mask) == '0;

endmodule

// File: rtl/dsp_mult_pattern_detect.sv
// Three-stage signed multiplier with a registered pattern-detect flag aligned to each product.
// Define DSP_PD_MASK_EN to add the pd_mask_i port (mask bit = 1 drops that bit from the compare).
module dsp_mult_pattern_detect
  import dsp_pd_pkg::*;
#(
  parameter int unsigned WIDTH_IN1 = WIDTH_IN1_DEF,
  parameter int unsigned WIDTH_IN2 = WIDTH_IN2_DEF,
  parameter int unsigned WIDTH_OUT = WIDTH_OUT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH_IN1:0]   a_i,
  input  logic [WIDTH_IN2:0]   b_i,
  input  logic [WIDTH_OUT:0]   pd_pattern_i,
`ifdef DSP_PD_MASK_EN
  input  logic [WIDTH_OUT:0]   pd_mask_i,
`endif
  output logic [WIDTH_OUT:0]   c_o,
  output logic                 ones_o
);

  localparam int unsigned ProdW = WIDTH_IN1 + WIDTH_IN2 + 2;

  logic signed [WIDTH_IN1:0] a_q;
  logic signed [WIDTH_IN2:0] b_q;
  logic [WIDTH_OUT:0]        pat1_q;
  logic [WIDTH_OUT:0]        pat2_q;
  logic [WIDTH_OUT:0]        ab_q;
  logic                      ones_q;
  logic [WIDTH_OUT:0]        mask2;
  logic                      match;

  logic signed [ProdW-1:0]   a_ext;
  logic signed [ProdW-1:0]   b_ext;
  logic signed [ProdW-1:0]   prod_full;
  logic [WIDTH_OUT:0]        ab_d;

  // Sign-extend to the full product width so the multiply never truncates early.
  assign a_ext     = ProdW'(a_q);
  assign b_ext     = ProdW'(b_q);
  assign prod_full = a_ext * b_ext;
  assign ab_d      = prod_full[WIDTH_OUT:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      pat1_q <= '0;
      pat2_q <= '0;
      ab_q   <= '0;
      ones_q <= 1'b0;
    end else begin
      a_q    <= a_i;
      b_q    <= b_i;
      pat1_q <= pd_pattern_i;
      pat2_q <= pat1_q;
      ab_q   <= ab_d;
      ones_q <= match;
    end
  end

`ifdef DSP_PD_MASK_EN
  logic [WIDTH_OUT:0] mask1_q;
  logic [WIDTH_OUT:0] mask2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask1_q <= '0;
      mask2_q <= '0;
    end else begin
      mask1_q <= pd_mask_i;
      mask2_q <= mask1_q;
    end
  end

  assign mask2 = mask2_q;
`else
  assign mask2 = '0;
`endif

  dsp_pd_cmp #(
    .WIDTH (WIDTH_OUT + 1)
  ) u_cmp (
    .value   (ab_q),
    .pattern (pat2_q),
    .mask    (mask2),
    .match   (match)
  );

  assign c_o    = ab_q;
  assign ones_o = ones_q;

endmodule

// File: tb/tb_dsp_mult_pattern_detect.sv
// Randomized and directed bench for dsp_mult_pattern_detect against an edge-indexed history model.
module tb_dsp_mult_pattern_detect;

  localparam int W1   = 26;
  localparam int W2   = 14;
  localparam int WO   = 40;
  localparam int MAXE = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W1:0]   a = '0;
  logic [W2:0]   b = '0;
  logic [WO:0]   pat = '0;
  logic [WO:0]   mask = '0;
  logic [WO:0]   c;
  logic          ones;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 2;

  // Per-edge record of what each captured sample should produce.
  logic [WO:0] hc [MAXE];
  logic        hm [MAXE];
  logic        hr [MAXE];

  dsp_mult_pattern_detect dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_i          (a),
    .b_i          (b),
    .pd_pattern_i (pat),
`ifdef DSP_PD_MASK_EN
    .pd_mask_i    (mask),
`endif
    .c_o          (c),
    .ones_o       (ones)
  );

  always #5 clk = ~clk;

  function automatic logic [WO:0] ref_prod(input logic [W1:0] x, input logic [W2:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[WO:0];
  endfunction

  task automatic check(input string tag, input logic [WO:0] got, input logic [WO:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [W1:0] ta, input logic [W2:0] tb, input logic [WO:0] tp,
                      input logic [WO:0] tm);
    logic [WO:0] m;
    a    = ta;
    b    = tb;
    pat  = tp;
    mask = tm;
`ifdef DSP_PD_MASK_EN
    m = tm;
`else
    m = '0;
`endif
    @(posedge clk);
    e++;
    if (rst_n) begin
      hc[e] = ref_prod(ta, tb);
      hm[e] = ((hc[e] ^ tp) & ~m) == '0;
      hr[e] = 1'b0;
    end else begin
      hc[e] = '0;
      hm[e] = 1'b1;
      hr[e] = 1'b1;
    end
    #1;
    check("c_o model", c, hr[e] ? '0 : hc[e-1]);
    check("ones_o model", 41'(ones), hr[e] ? '0 : 41'(hm[e-2]));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("c_o async reset", c, '0);
    check("ones_o async reset", 41'(ones), '0);
    // Samples already inside the pipeline are flushed.
    hc[e]   = '0;
    hm[e]   = 1'b1;
    hc[e-1] = '0;
    hm[e-1] = 1'b1;
    tick(27'($urandom), 15'($urandom), 41'({$urandom, $urandom}), '0);
    rst_n = 1'b1;
  endtask

  logic [W1:0] ra;
  logic [W2:0] rb;
  logic [WO:0] rp;
  logic [WO:0] rm;
  logic [WO:0] neg21;

  initial begin
    for (int i = 0; i < MAXE; i++) begin
      hc[i] = '0;
      hm[i] = 1'b1;
      hr[i] = 1'b0;
    end
    neg21 = -41'sd21;

    #1 rst_n = 1'b0;
    #1;
    check("c_o in reset", c, '0);
    check("ones_o in reset", 41'(ones), '0);
    for (int i = 0; i < 3; i++) tick('0, '0, '0, '0);
    rst_n = 1'b1;
    tick('0, '0, '0, '0);
    check("ones_o first edge after release", 41'(ones), 41'd1);

    tick(27'd10, 15'd10, 41'd100, '0);
    tick(27'd10, 15'd14, 41'd140, '0);
    check("c_o 10*10", c, 41'd100);
    tick(27'd3, 15'd5, 41'd16, '0);
    check("c_o 10*14", c, 41'd140);
    check("ones_o 10*10", 41'(ones), 41'd1);
    tick(-27'sd3, 15'sd7, neg21, '0);
    check("c_o 3*5", c, 41'd15);
    check("ones_o 10*14", 41'(ones), 41'd1);
    tick(27'h400_0000, 15'h4000, 41'h100_0000_0000, '0);
    check("c_o -3*7", c, neg21);
    check("ones_o 3*5 vs 16", 41'(ones), 41'd0);
    tick(27'h3FF_FFFF, 15'h3FFF, 41'd1099444502529, '0);
    check("c_o min*min wrap", c, 41'h100_0000_0000);
    check("ones_o -3*7", 41'(ones), 41'd1);
    tick('0, '0, 41'd5, '0);
    check("c_o max*max", c, 41'd1099444502529);
    check("ones_o wrap", 41'(ones), 41'd1);
    tick('0, '0, '0, '0);
    check("ones_o max*max", 41'(ones), 41'd1);
    check("c_o zero", c, '0);
    tick('0, '0, '0, '0);
    check("ones_o 0 vs 5", 41'(ones), 41'd0);

`ifdef DSP_PD_MASK_EN
    tick(27'd10, 15'd10, 41'h6F, 41'hF);
    tick(27'd10, 15'd10, 41'h6F, 41'h0);
    tick('0, '0, '0, '0);
    check("ones_o masked", 41'(ones), 41'd1);
    tick('0, '0, '0, '0);
    check("ones_o unmasked", 41'(ones), 41'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      if (i == 200) pulse_reset();
      ra = 27'($urandom);
      rb = 15'($urandom);
      rm = 41'({$urandom, $urandom}) & 41'h0FF;
      if ($urandom_range(0, 1) == 1) rp = ref_prod(ra, rb) ^ (rm & 41'(($urandom_range(0, 1))));
      else rp = 41'({$urandom, $urandom});
      tick(ra, rb, rp, rm);
    end
    tick('0, '0, '0, '0);
    tick('0, '0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
